if_id_fifo: RTL and testbench

//  Decoupling buffer between the IF stage and the ID stage. It accepts fetched {pc, inst} packets

---
 rtl/if_id_pkg.sv | 15 +
 rtl/fetch_pkt_ram.sv | 27 ++
 rtl/if_id_fifo.sv | 99 +++++++++
 tb/tb_if_id_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared fetch-packet types and constants for the IF/ID decoupling buffer.
// Pure declarations; no timing or backpressure of its own.
package if_id_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_pkt_ram.sv
// DEPTH x fetch_pkt_t storage: one synchronous write port and one asynchronous read port.
// Write lands at the clock edge; the read port follows raddr combinationally. No backpressure.
module fetch_pkt_ram
    import if_id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fetch_pkt_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output fetch_pkt_t       rdata
);

    fetch_pkt_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_fifo.sv
// In-order IF->ID packet buffer with first-word fall-through and a single-cycle flush.
// A push shows on id_* one edge later at the earliest; if_ready depends only on occupancy.
module if_id_fifo
    import if_id_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [DATA_W-1:0]        if_inst,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [DATA_W-1:0]        id_inst,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       is_empty, is_full;
    logic       push, pop;
    fetch_pkt_t wr_pkt, head_pkt;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // Ready is a pure function of occupancy so ID stalls never reach IF combinationally.
    assign if_ready = !rst && !is_full;
    assign id_valid = !rst && !is_empty;

    assign push = if_valid && if_ready;
    assign pop  = id_valid && id_ready;

    assign wr_pkt.pc   = if_pc;
    assign wr_pkt.inst = if_inst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_pkt_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q),
        .wdata (wr_pkt),
        .raddr (rd_ptr_q),
        .rdata (head_pkt)
    );

    // Uninitialised storage must never leak out while the head is not valid.
    assign id_pc   = id_valid ? head_pkt.pc   : '0;
    assign id_inst = id_valid ? head_pkt.inst : NOP_INST;
    assign count   = count_q;

endmodule

// File: tb/tb_if_id_fifo.sv
module tb_if_id_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready = 1'b0;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    if_id_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Reference model: an ordered list of packets, bounded at DEPTH.
    logic [63:0] mq[$];
    bit          chk_en = 0;
    bit          m_push, m_pop;

    always @(posedge clk) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            m_push = if_valid && (mq.size() < DEPTH);
            m_pop  = id_ready && (mq.size() > 0);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({if_pc, if_inst});
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        ev;
            logic [63:0] head;
            ev   = !rst && (mq.size() > 0);
            head = (mq.size() > 0) ? mq[0] : 64'h0;
            chk("m_id_valid", 64'(id_valid), 64'(ev));
            chk("m_if_ready", 64'(if_ready), 64'(!rst && (mq.size() < DEPTH)));
            chk("m_count",    64'(count),    64'(mq.size()));
            chk("m_id_pc",    64'(id_pc),    ev ? 64'(head[63:32]) : 64'h0);
            chk("m_id_inst",  64'(id_inst),  ev ? 64'(head[31:0]) : 64'h13);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] pc);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = mk_inst(pc);
        cyc();
        if_valid = 1'b0;
    endtask

    logic [31:0] got[$];
    logic [31:0] drain_exp[4];
    int          idx, ncyc;
    bit          acc;

    initial begin
        // 1: reset
        cyc();
        cyc();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_inst", 64'(id_inst), 64'h13);
        chk("rst_if_ready", 64'(if_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_if_ready", 64'(if_ready), 64'd1);

        // 2: fill, refused push, drain
        id_ready = 1'b0;
        push1(32'h0);
        push1(32'h4);
        push1(32'h8);
        push1(32'hC);
        chk("full_count", 64'(count), 64'd4);
        chk("full_if_ready", 64'(if_ready), 64'd0);
        push1(32'h10);
        chk("refused_count", 64'(count), 64'd4);
        chk("refused_head", 64'(id_pc), 64'h0);
        drain_exp = '{32'h0, 32'h4, 32'h8, 32'hC};
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", 64'(id_pc), 64'(drain_exp[k]));
            chk("drain_inst", 64'(id_inst), 64'(mk_inst(drain_exp[k])));
            cyc();
        end
        chk("drain_empty", 64'(id_valid), 64'd0);
        chk("drain_empty_pc", 64'(id_pc), 64'd0);
        id_ready = 1'b0;

        // 3: simultaneous push and pop at count=2
        push1(32'h14);
        push1(32'h18);
        chk("pp_pre_count", 64'(count), 64'd2);
        if_valid = 1'b1; if_pc = 32'h20; if_inst = mk_inst(32'h20); id_ready = 1'b1;
        cyc();
        if_valid = 1'b0; id_ready = 1'b0;
        chk("pp_count", 64'(count), 64'd2);
        chk("pp_head", 64'(id_pc), 64'h18);
        id_ready = 1'b1;
        cyc();
        chk("pp_tail", 64'(id_pc), 64'h20);
        cyc();
        id_ready = 1'b0;
        chk("pp_empty", 64'(id_valid), 64'd0);

        // 4: flush wins over a concurrent push
        push1(32'h30);
        push1(32'h34);
        push1(32'h38);
        chk("fl_pre_count", 64'(count), 64'd3);
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h40; if_inst = mk_inst(32'h40);
        cyc();
        flush = 1'b0; if_valid = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_id_valid", 64'(id_valid), 64'd0);
        id_ready = 1'b1;
        cyc();
        cyc();
        chk("fl_never_40", 64'(id_valid), 64'd0);
        id_ready = 1'b0;

        // 5: ten packets with interleaved pops, pointers wrap twice
        idx = 0; ncyc = 0; got.delete();
        while (idx < 10 && ncyc < 200) begin
            if_valid = 1'b1;
            if_pc    = 32'(4 * idx);
            if_inst  = mk_inst(32'(4 * idx));
            id_ready = (ncyc % 3) != 0;
            #1;
            acc = if_ready;
            if (id_valid && id_ready) got.push_back(id_pc);
            cyc();
            if (acc) idx++;
            ncyc++;
        end
        if_valid = 1'b0;
        id_ready = 1'b1;
        #1;
        while (id_valid && ncyc < 200) begin
            got.push_back(id_pc);
            cyc();
            ncyc++;
        end
        id_ready = 1'b0;
        chk("wrap_budget", 64'(ncyc < 200), 64'd1);
        chk("wrap_n", 64'(got.size()), 64'd10);
        for (int k = 0; k < got.size(); k++) begin
            chk("wrap_order", 64'(got[k]), 64'(4 * k));
        end

        // 6: reset mid-operation, then first push after it
        push1(32'h50);
        push1(32'h54);
        chk("mr_pre_count", 64'(count), 64'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_id_valid", 64'(id_valid), 64'd0);
        push1(32'h100);
        chk("mr_new_valid", 64'(id_valid), 64'd1);
        chk("mr_new_pc", 64'(id_pc), 64'h100);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
